// File: rtl/router_pkg.sv
// Shared router/NIC definitions: packet width, field positions, NIC register map, packet layout.
package router_pkg;

    localparam int DW = 64;
    localparam int AW = 2;

    localparam int VC_BIT  = 63;
    localparam int DX_BIT  = 62;
    localparam int DY_BIT  = 61;
    localparam int RSV_MSB = 60;
    localparam int RSV_LSB = 56;
    localparam int HX_MSB  = 55;
    localparam int HX_LSB  = 52;
    localparam int HY_MSB  = 51;
    localparam int HY_LSB  = 48;
    localparam int SX_MSB  = 47;
    localparam int SX_LSB  = 40;
    localparam int SY_MSB  = 39;
    localparam int SY_LSB  = 32;
    localparam int PL_MSB  = 31;
    localparam int PL_LSB  = 0;

    localparam logic [1:0] ADDR_IN_BUF   = 2'd0;
    localparam logic [1:0] ADDR_IN_STAT  = 2'd1;
    localparam logic [1:0] ADDR_OUT_BUF  = 2'd2;
    localparam logic [1:0] ADDR_OUT_STAT = 2'd3;

    typedef struct packed {
        logic        vc;
        logic        dx;
        logic        dy;
        logic [4:0]  rsv;
        logic [3:0]  hx;
        logic [3:0]  hy;
        logic [7:0]  sx;
        logic [7:0]  sy;
        logic [31:0] payload;
    } packet_t;

endpackage

// File: rtl/nic_slot_buf.sv
// Single-entry packet holding register with a full flag; load wins over clear.
module nic_slot_buf #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          clear,
    output logic [DW-1:0] data,
    output logic          full
);

    logic [DW-1:0] data_q, data_d;
    logic          full_q, full_d;

    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (clear) begin
            full_d = 1'b0;
        end
        if (load) begin
            data_d = load_data;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign data = data_q;
    assign full = full_q;

endmodule

// File: rtl/pe_nic_block.sv
// PE <-> router network interface: register-mapped PE side, 1-deep handshake net side.
// Optional sticky OUT_BUF overflow flag (OUT_STAT bit1) enabled by macro NIC_OVF_FLAG_EN.
module pe_nic_block #(
    parameter int DW = 64,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          phase_external,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] d_in,
    output logic [DW-1:0] d_out,
    input  logic          nicEn,
    input  logic          nicWrEn,
    output logic          net_so,
    input  logic          net_ro,
    output logic [DW-1:0] net_do,
    input  logic          net_si,
    output logic          net_ri,
    input  logic [DW-1:0] net_di
);

    import router_pkg::*;

    logic          pe_wr;
    logic          pe_rd;
    logic          out_load;
    logic          out_clear;
    logic          in_load;
    logic          in_clear;
    logic [DW-1:0] out_data;
    logic [DW-1:0] in_data;
    logic          out_full;
    logic          in_full;
    logic          ovf_bit;
    logic [DW-1:0] d_out_q, d_out_d;

    assign pe_wr = nicEn & nicWrEn;
    assign pe_rd = nicEn & ~nicWrEn;

    // All decisions use pre-edge full flags, so a write racing a drain is still dropped.
    assign out_load  = pe_wr & (addr == AW'(ADDR_OUT_BUF)) & ~out_full;
    assign out_clear = net_so & net_ro;
    assign in_load   = net_si & net_ri;
    assign in_clear  = pe_rd & (addr == AW'(ADDR_IN_BUF)) & in_full;

    assign net_so = out_full & phase_external;
    assign net_do = out_data;
    assign net_ri = ~in_full & phase_external & ~reset;

    nic_slot_buf #(.DW(DW)) u_out_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (out_load),
        .load_data (d_in),
        .clear     (out_clear),
        .data      (out_data),
        .full      (out_full)
    );

    nic_slot_buf #(.DW(DW)) u_in_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (in_load),
        .load_data (net_di),
        .clear     (in_clear),
        .data      (in_data),
        .full      (in_full)
    );

`ifdef NIC_OVF_FLAG_EN
    logic out_drop;
    logic ovf_q, ovf_d;

    assign out_drop = pe_wr & (addr == AW'(ADDR_OUT_BUF)) & out_full;

    always_comb begin
        ovf_d = ovf_q;
        if (pe_rd && (addr == AW'(ADDR_OUT_STAT))) begin
            ovf_d = 1'b0;
        end
        if (out_drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_bit = ovf_q;
`else
    assign ovf_bit = 1'b0;
`endif

    always_comb begin
        d_out_d = d_out_q;
        if (pe_rd) begin
            case (addr)
                AW'(ADDR_IN_BUF):   d_out_d = in_data;
                AW'(ADDR_IN_STAT):  d_out_d = {{(DW-1){1'b0}}, in_full};
                AW'(ADDR_OUT_STAT): d_out_d = {{(DW-2){1'b0}}, ovf_bit, out_full};
                default:            d_out_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_out_q <= '0;
        end else begin
            d_out_q <= d_out_d;
        end
    end

    assign d_out = d_out_q;

endmodule

// File: tb/tb_pe_nic_block.sv
// Directed bench for pe_nic_block: expected PE reads and net injections are queued, a monitor checks them.
`timescale 1ns/1ps
module tb_pe_nic_block;

    logic        clk = 1'b0;
    logic        reset;
    logic        phase_external;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;

    int total = 0;
    int bad   = 0;

    logic [63:0] rd_q[$];
    logic [63:0] net_q[$];
    logic        rd_pend;

    localparam logic [63:0] PKT_A = 64'h0030_0101_ABCD_0001;
    localparam logic [63:0] PKT_B = 64'h4000_1111_2222_3333;
    localparam logic [63:0] PKT_C = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] PKT_D = 64'h2000_0000_0000_00D0;
    localparam logic [63:0] PKT_E = 64'h8000_0202_DEAD_BEEF;
    localparam logic [63:0] PKT_F = 64'h1111_2222_3333_4444;

`ifdef NIC_OVF_FLAG_EN
    localparam logic [63:0] STAT_OVF = 64'd3;
`else
    localparam logic [63:0] STAT_OVF = 64'd1;
`endif

    always #5 clk = ~clk;

    pe_nic_block dut (
        .clk            (clk),
        .reset          (reset),
        .phase_external (phase_external),
        .addr           (addr),
        .d_in           (d_in),
        .d_out          (d_out),
        .nicEn          (nicEn),
        .nicWrEn        (nicWrEn),
        .net_so         (net_so),
        .net_ro         (net_ro),
        .net_do         (net_do),
        .net_si         (net_si),
        .net_ri         (net_ri),
        .net_di         (net_di)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic pe_write(input logic [1:0] a, input logic [63:0] d);
        addr = a; d_in = d; nicEn = 1'b1; nicWrEn = 1'b1;
        cyc();
        nicEn = 1'b0; nicWrEn = 1'b0;
    endtask

    task automatic pe_read(input logic [1:0] a, input logic [63:0] exp);
        rd_q.push_back(exp);
        addr = a; nicEn = 1'b1; nicWrEn = 1'b0;
        cyc();
        nicEn = 1'b0;
    endtask

    // Monitor: reads checked one edge after issue, injections checked while the handshake is up.
    initial begin
        rd_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rd_pend) begin
                if (rd_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rd_data: got %h with no expected entry", d_out);
                end else begin
                    chk("rd_data", d_out, rd_q.pop_front());
                end
            end
            rd_pend = nicEn && !nicWrEn && !reset;
            if (net_so && net_ro) begin
                if (net_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL net_do: unexpected transfer of %h", net_do);
                end else begin
                    chk("net_do", net_do, net_q.pop_front());
                end
            end
        end
    end

    initial begin
        reset = 1'b1; phase_external = 1'b0; addr = 2'd0; d_in = '0;
        nicEn = 1'b0; nicWrEn = 1'b0; net_ro = 1'b0; net_si = 1'b0; net_di = '0;
        #3;
        chk("rst_d_out", d_out, 64'd0);
        chk("rst_net_so", {63'd0, net_so}, 64'd0);
        chk("rst_net_ri", {63'd0, net_ri}, 64'd0);
        chk("rst_net_do", net_do, 64'd0);
        cyc();
        reset = 1'b0;

        // Async reset with OUT full discards it immediately.
        pe_write(2'd2, PKT_A);
        chk("gated_net_so", {63'd0, net_so}, 64'd0);
        pe_read(2'd3, 64'd1);
        cyc();
        #4;
        reset = 1'b1;
        #1;
        chk("midrst_net_so", {63'd0, net_so}, 64'd0);
        chk("midrst_d_out", d_out, 64'd0);
        chk("midrst_net_do", net_do, 64'd0);
        cyc();
        reset = 1'b0; phase_external = 1'b1; net_ro = 1'b1;
        chk("postrst_net_so", {63'd0, net_so}, 64'd0);
        pe_read(2'd3, 64'd0);

        // Injection with router ready.
        net_q.push_back(PKT_A);
        pe_write(2'd2, PKT_A);
        chk("inj_net_so", {63'd0, net_so}, 64'd1);
        cyc();
        chk("inj_drained", {63'd0, net_so}, 64'd0);
        pe_read(2'd3, 64'd0);

        // Backpressure: packet held, second write dropped.
        net_ro = 1'b0;
        pe_write(2'd2, PKT_B);
        for (int i = 0; i < 3; i++) begin
            chk("bp_net_so", {63'd0, net_so}, 64'd1);
            chk("bp_net_do", net_do, PKT_B);
            cyc();
        end
        pe_write(2'd2, PKT_C);
        chk("drop_net_do", net_do, PKT_B);
        pe_read(2'd3, STAT_OVF);
        pe_read(2'd3, 64'd1);
        net_q.push_back(PKT_B);
        net_ro = 1'b1;
        cyc();
        chk("bp_drained", {63'd0, net_so}, 64'd0);

        // Phase gating: no net activity in internal phase.
        phase_external = 1'b0;
        pe_write(2'd2, PKT_D);
        cyc();
        chk("phase_net_so", {63'd0, net_so}, 64'd0);
        chk("phase_net_ri", {63'd0, net_ri}, 64'd0);
        pe_read(2'd3, 64'd1);
        net_q.push_back(PKT_D);
        phase_external = 1'b1;
        cyc();
        chk("phase_drained", {63'd0, net_so}, 64'd0);

        // Ejection, then a second offer while IN is full.
        net_si = 1'b1; net_di = PKT_E;
        chk("ej_net_ri", {63'd0, net_ri}, 64'd1);
        cyc();
        net_di = PKT_F;
        chk("full_net_ri", {63'd0, net_ri}, 64'd0);
        cyc();
        net_si = 1'b0;
        pe_read(2'd1, 64'd1);
        pe_read(2'd0, PKT_E);
        chk("ej_ri_back", {63'd0, net_ri}, 64'd1);
        pe_read(2'd1, 64'd0);
        pe_read(2'd0, PKT_E);
        pe_read(2'd1, 64'd0);

        // Writes to non-OUT_BUF registers are ignored; OUT_BUF reads as zero.
        pe_write(2'd1, 64'hFFFF);
        pe_write(2'd0, 64'hFFFF);
        pe_read(2'd1, 64'd0);
        pe_read(2'd2, 64'd0);
        pe_read(2'd3, 64'd0);

        repeat (3) cyc();
        chk("rd_q_empty", 64'(rd_q.size()), 64'd0);
        chk("net_q_empty", 64'(net_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
